// File: rtl/mine_field_generator_if.sv
// mine_field_generator_if: start request in, board-memory write stream and status out
interface mine_field_generator_if;
  logic       start;
  logic [7:0] bombs;
  logic       busy;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [7:0] wr_data;
  logic       done;
  logic [6:0] mines;
  modport master (output start, bombs, input busy, wr_en, wr_row, wr_col, wr_data, done, mines);
  modport slave (input start, bombs, output busy, wr_en, wr_row, wr_col, wr_data, done, mines);
endinterface

// File: rtl/mine_field_generator.sv
// mine_field_generator: places random mines on an 8x8 board and streams cell values row-major
module mine_field_generator #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_BOMBS = 63,
  parameter logic [7:0]  MINE_CODE = 8'h0F
) (
  input logic clk,
  input logic rst,
  mine_field_generator_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} state_t;
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [7:0]  MAX_N   = 8'(MAX_BOMBS);
  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] map_q, map_d;
  logic [6:0]  placed_q, placed_d, target_q, target_d, mines_q, mines_d;
  logic [5:0]  cell_q, cell_d, idx;
  logic        busy_q, busy_d, wr_en_q, wr_en_d, done_q, done_d;
  logic [2:0]  row_q, row_d, col_q, col_d;
  logic [7:0]  data_q, data_d;
  // In-bounds 8-neighbour popcount, no wrap-around at edges
  function automatic logic [3:0] nbr(input logic [63:0] m, input logic [5:0] k);
    logic [3:0] n;
    int r, c;
    n = '0;
    r = int'(k[5:3]);
    c = int'(k[2:0]);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
          n = n + {3'b0, m[6'((r + dr) * 8 + c + dc)]};
    return n;
  endfunction
  assign idx = lfsr_q[5:0];
  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    placed_d = placed_q;
    target_d = target_q;
    cell_d   = cell_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = CLEAR;
        target_d = (bus.bombs == 8'd0) ? 7'd1 : (bus.bombs > MAX_N ? MAX_N[6:0] : bus.bombs[6:0]);
      end
      CLEAR: begin
        map_d    = '0;
        placed_d = '0;
        state_d  = PLACE;
      end
      PLACE: if (placed_q == target_q) begin
        state_d = COUNT;
        cell_d  = '0;
      end else if (!map_q[idx]) begin
        map_d[idx] = 1'b1;
        placed_d   = placed_q + 7'd1;
      end
      COUNT: begin
        cell_d  = cell_q + 6'd1;
        state_d = (cell_q == 6'd63) ? DONE : COUNT;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it cycle for cycle
    busy_d  = state_d inside {CLEAR, PLACE, COUNT};
    wr_en_d = state_d == COUNT;
    done_d  = state_d == DONE;
    mines_d = (state_d == DONE) ? target_q : mines_q;
    row_d   = wr_en_d ? cell_d[5:3] : row_q;
    col_d   = wr_en_d ? cell_d[2:0] : col_q;
    data_d  = wr_en_d ? (map_q[cell_d] ? MINE_CODE : {4'h0, nbr(map_q, cell_d)}) : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_NZ;
      map_q    <= '0;
      placed_q <= '0;
      target_q <= '0;
      cell_q   <= '0;
      mines_q  <= '0;
      busy_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      map_q    <= map_d;
      placed_q <= placed_d;
      target_q <= target_d;
      cell_q   <= cell_d;
      mines_q  <= mines_d;
      busy_q   <= busy_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
      row_q    <= row_d;
      col_q    <= col_d;
      data_q   <= data_d;
    end
  end
  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_row  = row_q;
  assign bus.wr_col  = col_q;
  assign bus.wr_data = data_q;
  assign bus.done    = done_q;
  assign bus.mines   = mines_q;
endmodule
